// File: rtl/cby_cfg_bank_ctrl_pkg.sv
// cby_cfg_pkg: shared states and parameter helpers for the connection-block config sequencer
package cby_cfg_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, PULSE, SETTLE, DONE} cfg_state_t;
   function automatic int words_per_row(input int n_bl, input int dw);
      return n_bl / dw;
   endfunction
   function automatic bit cfg_params_ok(input int n_bl, input int dw, input int wl_pulse);
      return dw > 0 && n_bl >= dw && n_bl % dw == 0 && wl_pulse >= 1;
   endfunction
endpackage

// File: rtl/cby_cfg_bank_ctrl_if.sv
// cby_cfg_bank_ctrl_if: start request plus valid/ready configuration word stream
interface cby_cfg_bank_ctrl_if #(parameter int DW = 8);
   logic          cfg_start;
   logic [DW-1:0] cfg_data;
   logic          cfg_valid;
   logic          cfg_ready;
   modport master (output cfg_start, cfg_data, cfg_valid, input cfg_ready);
   modport slave  (input cfg_start, cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/cby_cfg_bank_ctrl_wl_decoder.sv
// cfg_wl_decoder: registered binary-to-one-hot wordline driver
module cfg_wl_decoder #(
   parameter int N_WL = 1,
   parameter int RW   = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RW-1:0] row,
   input  logic          pulse_en,
   output logic [0:N_WL-1] wl
);
   logic [0:N_WL-1] wl_nxt;
   // one-hot select of the addressed row, all zero when not pulsing
   always_comb begin
      wl_nxt = '0;
      for (int i = 0; i < N_WL; i++) wl_nxt[i] = pulse_en && int'(row) == i;
   end
   // register the wordlines so they never glitch on the bank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wl <= '0;
      else     wl <= wl_nxt;
   end
endmodule

// File: rtl/cby_cfg_bank_ctrl.sv
// cby_cfg_bank_ctrl: assembles config words into bitline rows and pulses wordlines
module cby_cfg_bank_ctrl
   import cby_cfg_pkg::*;
#(
   parameter int N_BL     = 80,
   parameter int N_WL     = 1,
   parameter int DW       = 8,
   parameter int WL_PULSE = 2
) (
   input  logic            prog_clk,
   input  logic            pReset,
   cby_cfg_bank_ctrl_if.slave cfg,
   output logic [0:N_BL-1] bl,
   output logic [0:N_WL-1] wl,
   output logic            cfg_busy,
   output logic            cfg_done,
   output logic            cfg_err
);
   localparam int WPR = words_per_row(N_BL, DW);
   localparam int WW  = WPR > 1 ? $clog2(WPR) : 1;
   localparam int RW  = N_WL > 1 ? $clog2(N_WL) : 1;
   localparam int PW  = WL_PULSE > 1 ? $clog2(WL_PULSE) : 1;
   localparam logic [WW-1:0] LAST_WORD = WW'(WPR - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(N_WL - 1);
   localparam logic [PW-1:0] LAST_PCNT = PW'(WL_PULSE - 1);

   if (!cfg_params_ok(N_BL, DW, WL_PULSE)) begin : g_bad_params
      $error("cby_cfg_bank_ctrl: N_BL must be a multiple of DW and WL_PULSE must be >= 1");
   end

   cfg_state_t      state, state_nxt;
   logic [WW-1:0]   word;
   logic [RW-1:0]   row;
   logic [PW-1:0]   pcnt;
   logic            acc;

   assign acc = state == LOAD && cfg.cfg_valid;

   // next-state selection and Moore decode of the status outputs
   always_comb begin
      state_nxt     = state;
      cfg.cfg_ready = state == LOAD;
      cfg_busy      = state != IDLE;
      cfg_done      = state == DONE;
      unique case (state)
         IDLE:    if (cfg.cfg_start) state_nxt = LOAD;
         LOAD:    if (acc && word == LAST_WORD) state_nxt = PULSE;
         PULSE:   if (pcnt == LAST_PCNT) state_nxt = SETTLE;
         SETTLE:  state_nxt = row == LAST_ROW ? DONE : LOAD;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state register, counters, bitline row assembly and sticky error flag
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state   <= IDLE;
         word    <= '0;
         row     <= '0;
         pcnt    <= '0;
         bl      <= '0;
         cfg_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && cfg.cfg_start) begin
            word    <= '0;
            row     <= '0;
            bl      <= '0;
            cfg_err <= 1'b0;
         end else if (cfg.cfg_start) begin
            cfg_err <= 1'b1;
         end
         if (acc) begin
            bl[int'(word)*DW +: DW] <= cfg.cfg_data;
            word                    <= word + 1'b1;
         end
         if (state == LOAD) pcnt <= '0;
         else if (state == PULSE) pcnt <= pcnt + 1'b1;
         if (state == SETTLE && row != LAST_ROW) begin
            row  <= row + 1'b1;
            word <= '0;
         end
      end
   end

   cfg_wl_decoder #(.N_WL(N_WL), .RW(RW)) u_wl_dec (
      .clk      (prog_clk),
      .rst      (pReset),
      .row      (row),
      .pulse_en (state_nxt == PULSE),
      .wl       (wl)
   );
endmodule

// File: tb/tb_cby_cfg_bank_ctrl.sv
// tb_cby_cfg_bank_ctrl: directed and random checks of the bank config sequencer
module tb_cby_cfg_bank_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cby_cfg_bank_ctrl_if #(.DW(8)) c0 ();
   cby_cfg_bank_ctrl_if #(.DW(8)) c1 ();

   logic [0:79] bl0;
   logic [0:0]  wl0;
   logic        busy0, done0, err0;
   logic [0:15] bl1;
   logic [0:3]  wl1;
   logic        busy1, done1, err1;

   cby_cfg_bank_ctrl dut0 (
      .prog_clk(clk), .pReset(rst), .cfg(c0), .bl(bl0), .wl(wl0),
      .cfg_busy(busy0), .cfg_done(done0), .cfg_err(err0)
   );
   cby_cfg_bank_ctrl #(.N_BL(16), .N_WL(4), .DW(8), .WL_PULSE(2)) dut1 (
      .prog_clk(clk), .pReset(rst), .cfg(c1), .bl(bl1), .wl(wl1),
      .cfg_busy(busy1), .cfg_done(done1), .cfg_err(err1)
   );

   int n_run = 0;
   int n_fail = 0;
   logic [7:0] d [10];
   logic [7:0] e [8];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [0:79] exp_row();
      logic [0:79] r;
      for (int w = 0; w < 10; w++)
         for (int b = 0; b < 8; b++) r[w*8+b] = d[w][7-b];
      return r;
   endfunction

   task automatic run0(input int stall_at, input int stall_len, input int start_at, input bit rnd,
                       output int rise, output int fall, output int done_c, output int idle_c,
                       output int n_done, output int bad, output logic [0:79] blr);
      int wi = 0;
      int sc = 0;
      logic v, va;
      rise = -1; fall = -1; done_c = -1; idle_c = -1; n_done = 0; bad = 0; blr = '0;
      c0.cfg_start = 1'b1;
      tick;
      c0.cfg_start = 1'b0;
      for (int cyc = 1; cyc < 300 && idle_c < 0; cyc++) begin
         if (wl0[0] && rise < 0) begin rise = cyc; blr = bl0; end
         if (!wl0[0] && rise >= 0 && fall < 0) fall = cyc;
         if (done0) begin n_done++; done_c = cyc; end
         if (!busy0) idle_c = cyc;
         if (wl0 != '0 && c0.cfg_ready) bad++;
         v = wi < 10 && !(wi == stall_at && sc < stall_len) && (!rnd || $urandom_range(0, 2) != 0);
         if (wi == stall_at && sc < stall_len) sc++;
         c0.cfg_valid = v;
         c0.cfg_data  = d[wi < 10 ? wi : 0];
         c0.cfg_start = cyc == start_at;
         va = v && c0.cfg_ready;
         tick;
         if (va) wi++;
      end
      c0.cfg_valid = 1'b0;
      c0.cfg_start = 1'b0;
   endtask

   task automatic run1(output int nr, output int n_done, output int done_c, output int bad,
                       output int rises [4], output logic [0:3] wlv [4], output logic [0:15] blv [4]);
      int wi = 0;
      logic [0:3] prev = '0;
      logic v, va;
      nr = 0; n_done = 0; done_c = -1; bad = 0;
      for (int i = 0; i < 4; i++) begin rises[i] = -1; wlv[i] = '0; blv[i] = '0; end
      c1.cfg_start = 1'b1;
      tick;
      c1.cfg_start = 1'b0;
      for (int cyc = 1; cyc < 60; cyc++) begin
         if (wl1 != '0 && prev == '0 && nr < 4) begin
            rises[nr] = cyc; wlv[nr] = wl1; blv[nr] = bl1; nr++;
         end
         if ($countones(wl1) > 1 || (wl1 != '0 && c1.cfg_ready)) bad++;
         if (done1) begin n_done++; done_c = cyc; end
         prev = wl1;
         v = wi < 8;
         c1.cfg_valid = v;
         c1.cfg_data  = e[wi < 8 ? wi : 0];
         va = v && c1.cfg_ready;
         tick;
         if (va) wi++;
      end
      c1.cfg_valid = 1'b0;
   endtask

   initial begin
      int rise, fall, done_c, idle_c, n_done, bad, nr, hi;
      logic [0:79] blr;
      int rises [4];
      logic [0:3] wlv [4];
      logic [0:15] blv [4];
      c0.cfg_start = 0; c0.cfg_valid = 0; c0.cfg_data = '0;
      c1.cfg_start = 0; c1.cfg_valid = 0; c1.cfg_data = '0;
      repeat (2) tick;
      chk("rst_bl", bl0, 0);
      chk("rst_wl", wl0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_err", err0, 0);
      chk("rst_ready", c0.cfg_ready, 0);
      rst = 1'b0;
      tick;

      d[0] = 8'hA5;
      for (int i = 1; i < 10; i++) d[i] = 8'(i);
      run0(-1, 0, -1, 1'b0, rise, fall, done_c, idle_c, n_done, bad, blr);
      chk("basic_rise", rise, 11);
      chk("basic_fall", fall, 13);
      chk("basic_done", done_c, 14);
      chk("basic_idle", idle_c, 15);
      chk("basic_ndone", n_done, 1);
      chk("basic_wl_ready", bad, 0);
      chk("basic_bl0_7", blr[0:7], 8'hA5);
      chk("basic_bl8_15", blr[8:15], 8'h01);
      chk("basic_row", blr, exp_row());
      chk("basic_retain", bl0, exp_row());

      run0(4, 3, -1, 1'b0, rise, fall, done_c, idle_c, n_done, bad, blr);
      chk("stall_rise", rise, 14);
      chk("stall_idle", idle_c, 18);
      chk("stall_row", blr, exp_row());

      run0(-1, 0, 11, 1'b0, rise, fall, done_c, idle_c, n_done, bad, blr);
      chk("busy_start_done", done_c, 14);
      chk("busy_start_ndone", n_done, 1);
      chk("busy_start_err", err0, 1);
      repeat (3) tick;
      chk("err_sticky", err0, 1);
      run0(-1, 0, -1, 1'b0, rise, fall, done_c, idle_c, n_done, bad, blr);
      chk("err_cleared", err0, 0);
      chk("restart_rise", rise, 11);

      run0(-1, 0, 14, 1'b0, rise, fall, done_c, idle_c, n_done, bad, blr);
      chk("done_start_idle", idle_c, 15);
      chk("done_start_err", err0, 1);

      c0.cfg_start = 1'b1;
      tick;
      c0.cfg_start = 1'b0;
      c0.cfg_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin c0.cfg_data = 8'hFF; tick; end
      rst = 1'b1;
      #1;
      chk("mrst_bl", bl0, 0);
      chk("mrst_wl", wl0, 0);
      chk("mrst_busy", busy0, 0);
      chk("mrst_ready", c0.cfg_ready, 0);
      chk("mrst_err", err0, 0);
      hi = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) rst = 1'b0;
         if (wl0 != '0) hi++;
         tick;
      end
      c0.cfg_valid = 1'b0;
      chk("mrst_no_pulse", hi, 0);
      run0(-1, 0, -1, 1'b0, rise, fall, done_c, idle_c, n_done, bad, blr);
      chk("mrst_fresh_rise", rise, 11);
      chk("mrst_fresh_row", blr, exp_row());

      e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run1(nr, n_done, done_c, bad, rises, wlv, blv);
      chk("mr_rows", nr, 4);
      chk("mr_ndone", n_done, 1);
      chk("mr_done", done_c, 21);
      chk("mr_overlap", bad, 0);
      chk("mr_rise0", rises[0], 3);
      chk("mr_rise1", rises[1], 8);
      chk("mr_rise2", rises[2], 13);
      chk("mr_rise3", rises[3], 18);
      chk("mr_wl0", wlv[0], 4'b1000);
      chk("mr_wl1", wlv[1], 4'b0100);
      chk("mr_wl2", wlv[2], 4'b0010);
      chk("mr_wl3", wlv[3], 4'b0001);
      chk("mr_bl0", blv[0], 16'h1122);
      chk("mr_bl1", blv[1], 16'h3344);
      chk("mr_bl2", blv[2], 16'h5566);
      chk("mr_bl3", blv[3], 16'h7788);

      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) d[i] = 8'($urandom);
         run0(-1, 0, -1, 1'b1, rise, fall, done_c, idle_c, n_done, bad, blr);
         chk("rnd_row", blr, exp_row());
         chk("rnd_wl_ready", bad, 0);
         chk("rnd_ndone", n_done, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
